// File: rtl/axi4_wr_pkg.sv
// Shared types and constants for the AXI4 frame writer.
package axi4_wr_pkg;

  // Writer FSM state encoding (also exported on the debug state port)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [3:0] AWCACHE_DEF = 4'b0011;
  localparam logic [2:0] AWPROT_DEF  = 3'b000;

  // Ceiling log2, used to derive AWSIZE from the data width
  function automatic int clog2(input int unsigned value);
    int r;
    r = 0;
    while ((32'd1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4_frame_writer_fb_addr_gen.sv
// Frame-buffer address generator: tracks the write offset inside the
// current frame, rotates buffers on frame completion and handles resync.
module fb_addr_gen
  import axi4_wr_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 64,
  parameter int          BURST_LEN   = 64,
  parameter int          FRAME_WORDS = 19200,
  parameter int          NUM_BUFS    = 3,
  parameter int unsigned BUF_STRIDE  = 32'h0004_0000
) (
  input  logic              clk_100Mhz,
  input  logic              rst,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              frame_sync,
  input  logic              in_idle,
  input  logic              start,
  input  logic              resp_done,
  input  logic [7:0]        cur_awlen,
  output logic [8:0]        cur_len,
  output logic [ADDR_W-1:0] burst_addr,
  output logic [7:0]        burst_awlen,
  output logic [1:0]        wr_buf_idx,
  output logic [1:0]        done_buf_idx,
  output logic              frame_done
);

  localparam int OFF_W   = $clog2(FRAME_WORDS + 1);
  localparam int BYTE_SH = clog2(DATA_W / 8);

  logic [OFF_W-1:0] word_off;
  logic             sync_pend;
  int               remain_words;
  int               next_off;
  logic             frame_end;

  // Next burst size: full burst, or whatever is left of the frame
  always_comb begin
    remain_words = FRAME_WORDS - int'(word_off);
    if (remain_words < BURST_LEN) begin
      cur_len = 9'(remain_words);
    end else begin
      cur_len = 9'(BURST_LEN);
    end
    burst_awlen = 8'(cur_len - 9'd1);
    burst_addr  = base_addr
                + ADDR_W'(wr_buf_idx) * ADDR_W'(BUF_STRIDE)
                + (ADDR_W'(word_off) << BYTE_SH);
    next_off    = int'(word_off) + int'(cur_awlen) + 1;
    frame_end   = (next_off == FRAME_WORDS);
  end

  // Offset/buffer bookkeeping, advanced when the burst response arrives
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      word_off     <= '0;
      wr_buf_idx   <= 2'd0;
      done_buf_idx <= 2'(NUM_BUFS - 1);
      sync_pend    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (resp_done) begin
        // Completing a frame beats a resync that lands on the same cycle,
        // but a resync requested earlier suppresses the buffer advance.
        if (frame_end && !sync_pend) begin
          word_off     <= '0;
          done_buf_idx <= wr_buf_idx;
          wr_buf_idx   <= (wr_buf_idx == 2'(NUM_BUFS - 1)) ? 2'd0 : wr_buf_idx + 2'd1;
          frame_done   <= 1'b1;
        end else if (sync_pend || frame_sync) begin
          word_off <= '0;
        end else begin
          word_off <= OFF_W'(next_off);
        end
        sync_pend <= 1'b0;
      end else if (frame_sync) begin
        // A sync on the IDLE exit edge belongs to the burst being launched
        if (in_idle && !start) begin
          word_off <= '0;
        end else begin
          sync_pend <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi4_frame_writer.sv
// AXI4 write master draining an FWFT pixel FIFO into rotating frame buffers.
// Handshakes: a transfer on any channel happens on a rising clk edge where
// both VALID and READY are high; a raised VALID is held with stable payload
// until that edge, and READY may toggle freely.
module axi4_frame_writer
  import axi4_wr_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 64,
  parameter int          BURST_LEN   = 64,
  parameter int          FRAME_WORDS = 19200,
  parameter int          NUM_BUFS    = 3,
  parameter int unsigned BUF_STRIDE  = 32'h0004_0000,
  parameter int          LEVEL_W     = 10
) (
  input  logic                clk_100Mhz,
  input  logic                rst,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                frame_sync,
  input  logic                err_clr,
  input  logic [DATA_W-1:0]   fifo_dout,
  input  logic [LEVEL_W-1:0]  fifo_level,
  output logic                fifo_rd_en,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [7:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic [3:0]          AWCACHE,
  output logic [2:0]          AWPROT,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP,
  output logic                frame_done,
  output logic [1:0]          done_buf_idx,
  output logic [1:0]          wr_buf_idx,
  output logic                err_sticky,
  output logic [1:0]          state
);

  localparam int BYTES    = DATA_W / 8;
  localparam int SIZE_LOG = clog2(BYTES);

  // Bursts must tile 4 KB pages and a frame must fit inside its buffer
  if (((4096 % (BURST_LEN * BYTES)) != 0) || (FRAME_WORDS * BYTES > BUF_STRIDE)) begin : g_cfg_err
    $error("axi4_frame_writer: burst/frame geometry violates 4 KB boundary rules");
  end

  wr_state_t         st;
  logic [7:0]        beat_cnt;
  logic [8:0]        cur_len;
  logic [ADDR_W-1:0] burst_addr;
  logic [7:0]        burst_awlen;
  logic              start;
  logic              resp_done;

  assign start      = (st == ST_IDLE) && enable && (32'(fifo_level) >= 32'(cur_len));
  assign resp_done  = (st == ST_RESP) && BVALID;

  assign WVALID     = (st == ST_DATA);
  assign BREADY     = (st == ST_RESP);
  assign fifo_rd_en = WVALID && WREADY;
  assign WLAST      = WVALID && (beat_cnt == AWLEN);
  assign WDATA      = fifo_dout;
  assign WSTRB      = '1;
  assign AWSIZE     = 3'(SIZE_LOG);
  assign AWBURST    = BURST_INCR;
  assign AWCACHE    = AWCACHE_DEF;
  assign AWPROT     = AWPROT_DEF;
  assign state      = st;

  fb_addr_gen #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .NUM_BUFS    (NUM_BUFS),
    .BUF_STRIDE  (BUF_STRIDE)
  ) u_addr_gen (
    .clk_100Mhz   (clk_100Mhz),
    .rst          (rst),
    .base_addr    (base_addr),
    .frame_sync   (frame_sync),
    .in_idle      (st == ST_IDLE),
    .start        (start),
    .resp_done    (resp_done),
    .cur_awlen    (AWLEN),
    .cur_len      (cur_len),
    .burst_addr   (burst_addr),
    .burst_awlen  (burst_awlen),
    .wr_buf_idx   (wr_buf_idx),
    .done_buf_idx (done_buf_idx),
    .frame_done   (frame_done)
  );

  // Burst FSM: one outstanding burst, AW strictly before W, then wait for B
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      st         <= ST_IDLE;
      AWVALID    <= 1'b0;
      AWADDR     <= '0;
      AWLEN      <= 8'd0;
      beat_cnt   <= 8'd0;
      err_sticky <= 1'b0;
    end else begin
      // A new error wins over a simultaneous clear
      if (resp_done && (BRESP != RESP_OKAY)) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
      case (st)
        ST_IDLE: begin
          if (start) begin
            AWADDR  <= burst_addr;
            AWLEN   <= burst_awlen;
            AWVALID <= 1'b1;
            st      <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (AWREADY) begin
            AWVALID <= 1'b0;
            st      <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (WREADY) begin
            if (beat_cnt == AWLEN) begin
              beat_cnt <= 8'd0;
              st       <= ST_RESP;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        ST_RESP: begin
          if (BVALID) begin
            st <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
